dtb_capture_ctrl: RTL

Write-side controller for the Data Trace Buffer. Takes a stream of 32-bit trace words with per-bit trigger flags and sequences writes into the TRB_DEPTH-entry BRAM ring. It detects the first trigger, then stops capture after a programmable number of post-trigger words. It publishes the trigger location as `status_t` for the readout path.

---
 rtl/dtb_capture_ctrl_if.sv | 51 +++++
 rtl/dtb_capture_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dtb_capture_ctrl_if.sv
// Data Trace Buffer shared types and the capture controller port bundle.
// The package travels with the interface so both the DUT and the bench see one definition.
package dtb_pkg;
   localparam int TRB_WIDTH      = 32;
   localparam int TRB_DEPTH      = 32;
   localparam int TRB_DELAY_BITS = 2;
   localparam int TRB_AW         = $clog2(TRB_DEPTH);
   localparam int TRB_PW         = $clog2(TRB_WIDTH);

   typedef struct packed {
      logic [7:0]                trg_num_traces;
      logic                      trg_mode;
      logic [TRB_DELAY_BITS-1:0] trg_delay;
   } control_t;

   typedef struct packed {
      logic              trg_event;
      logic [TRB_PW-1:0] event_pos;
      logic [TRB_AW-1:0] event_addr;
   } status_t;

   localparam status_t STATUS_DEFAULT = '0;
endpackage

interface dtb_capture_ctrl_if;
   import dtb_pkg::*;

   control_t               control_i;
   logic                   arm_i;
   logic                   valid_i;
   logic [TRB_WIDTH-1:0]   data_i;
   logic [TRB_WIDTH-1:0]   trigger_i;
   logic                   bram_we_o;
   logic [TRB_AW-1:0]      bram_addr_o;
   logic [TRB_WIDTH-1:0]   bram_data_o;
   status_t                status_o;
   logic                   busy_o;
   logic                   done_o;

   modport master (
      output control_i, arm_i, valid_i, data_i, trigger_i,
      input  bram_we_o, bram_addr_o, bram_data_o,
      input  status_o, busy_o, done_o
   );

   modport slave (
      input  control_i, arm_i, valid_i, data_i, trigger_i,
      output bram_we_o, bram_addr_o, bram_data_o,
      output status_o, busy_o, done_o
   );
endinterface

// File: rtl/dtb_capture_ctrl.sv
// Write-side controller for the Data Trace Buffer ring.
// Captures trace words, records the first trigger and stops after the post window.
module dtb_capture_ctrl
   import dtb_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   dtb_capture_ctrl_if.slave    bus
);

   localparam int CW = TRB_AW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_POST,
      S_DONE
   } state_t;

   state_t                 r_state, w_nxt;
   logic [TRB_AW-1:0]      r_wptr;
   logic [CW-1:0]          r_cnt, w_cnt;
   logic                   r_mode;
   logic [TRB_DELAY_BITS-1:0] r_delay;
   status_t                r_status, w_status;
   logic                   r_we, w_we;
   logic [TRB_AW-1:0]      r_addr;
   logic [TRB_WIDTH-1:0]   r_data;
   logic                   r_busy, r_done;
   logic                   w_clear;
   logic [CW-1:0]          w_load;
   logic                   w_unused;

   assign w_unused = ^bus.control_i.trg_num_traces;

   function automatic logic [TRB_PW-1:0] lsb_idx(input logic [TRB_WIDTH-1:0] v);
      lsb_idx = '0;
      for (int i = TRB_WIDTH-1; i >= 0; i--)
         if (v[i]) lsb_idx = TRB_PW'(i);
   endfunction

   assign w_load = CW'(r_delay) * CW'(TRB_DEPTH/4);

   always_comb begin
      w_nxt    = r_state;
      w_we     = 1'b0;
      w_cnt    = r_cnt;
      w_status = r_status;
      w_clear  = 1'b0;
      if (bus.arm_i) begin
         w_nxt   = S_CAPTURE;
         w_clear = 1'b1;
         w_cnt   = '0;
      end else begin
         unique case (r_state)
            S_CAPTURE: if (bus.valid_i) begin
               w_we = 1'b1;
               if (bus.trigger_i != '0) begin
                  w_status.trg_event  = 1'b1;
                  w_status.event_pos  = lsb_idx(bus.trigger_i);
                  w_status.event_addr = r_wptr;
                  w_cnt = w_load;
                  if (w_load != '0)
                     w_nxt = S_POST;
                  else if (!r_mode)
                     w_nxt = S_DONE;
               end
            end
            S_POST: if (bus.valid_i) begin
               w_we  = 1'b1;
               w_cnt = r_cnt - CW'(1);
               if (r_cnt == CW'(1))
                  w_nxt = r_mode ? S_CAPTURE : S_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_wptr   <= '0;
         r_cnt    <= '0;
         r_mode   <= 1'b0;
         r_delay  <= '0;
         r_status <= STATUS_DEFAULT;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt;
         r_we    <= w_we;
         r_busy  <= (w_nxt == S_CAPTURE) || (w_nxt == S_POST);
         r_done  <= (w_nxt == S_DONE);
         if (w_clear) begin
            r_wptr   <= '0;
            r_status <= STATUS_DEFAULT;
            r_mode   <= bus.control_i.trg_mode;
            r_delay  <= bus.control_i.trg_delay;
         end else begin
            r_status <= w_status;
            if (w_we) r_wptr <= r_wptr + TRB_AW'(1);
         end
         if (w_we) begin
            r_addr <= r_wptr;
            r_data <= bus.data_i;
         end
      end
   end

   assign bus.bram_we_o   = r_we;
   assign bus.bram_addr_o = r_addr;
   assign bus.bram_data_o = r_data;
   assign bus.status_o    = r_status;
   assign bus.busy_o      = r_busy;
   assign bus.done_o      = r_done;

endmodule
